// File: rtl/npu_dma_engine_if.sv
// NPU-side master port of the shared memory block, plus the burst status
// that accompanies each request.
interface npu_dma_engine_if;
  logic        npu_valid;
  logic        npu_ready;
  logic [63:0] npu_address;
  logic [63:0] npu_write_data;
  logic [7:0]  npu_byte_enable;
  logic        npu_write_enable;
  logic [63:0] npu_read_data;
  logic        burst_mode;
  logic [3:0]  burst_len;

  modport master (
    output npu_valid, npu_address, npu_write_data, npu_byte_enable,
           npu_write_enable, burst_mode, burst_len,
    input  npu_ready, npu_read_data
  );

  modport slave (
    input  npu_valid, npu_address, npu_write_data, npu_byte_enable,
           npu_write_enable, burst_mode, burst_len,
    output npu_ready, npu_read_data
  );
endinterface

// File: rtl/npu_dma_engine.sv
// Chunked memory-to-memory copy engine: reads up to BURST_MAX words into a
// local buffer, writes them to the destination, repeats until len_words done.
//
// state | meaning
// IDLE  | waiting for start; rejects misaligned or zero-length requests
// RD    | reading the current chunk from src into the buffer
// WR    | writing the buffered chunk to dst
// DONE  | one-cycle completion pulse, then back to IDLE
module npu_dma_engine #(
  parameter int BURST_MAX = 4,
  parameter int LEN_W     = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic [63:0]      src_addr,
  input  logic [63:0]      dst_addr,
  input  logic [LEN_W-1:0] len_words,
  output logic             busy,
  output logic             done,
  output logic             error,
  npu_dma_engine_if.master npu
);

  localparam int IW = (BURST_MAX > 1) ? $clog2(BURST_MAX) : 1;

  typedef enum logic [1:0] {IDLE, RD, WR, DONE} state_t;

  state_t           state;
  logic [63:0]      src;
  logic [63:0]      dst;
  logic [LEN_W-1:0] remaining;
  logic [3:0]       chunk;
  logic [3:0]       idx;
  logic [63:0]      buffer [2**IW];

  logic [LEN_W-1:0] rem_after;
  logic             last;

  assign rem_after = remaining - LEN_W'(chunk);
  assign last      = (idx == chunk - 4'd1);

  function automatic logic [3:0] chunk_of(input logic [LEN_W-1:0] n);
    if (n >= LEN_W'(BURST_MAX)) return 4'(BURST_MAX);
    return 4'(n);
  endfunction

  always_ff @(posedge clk) begin
    if (rst) begin
      state                <= IDLE;
      busy                 <= 1'b0;
      done                 <= 1'b0;
      error                <= 1'b0;
      src                  <= '0;
      dst                  <= '0;
      remaining            <= '0;
      chunk                <= '0;
      idx                  <= '0;
      npu.npu_valid        <= 1'b0;
      npu.npu_address      <= '0;
      npu.npu_write_data   <= '0;
      npu.npu_byte_enable  <= '0;
      npu.npu_write_enable <= 1'b0;
      npu.burst_mode       <= 1'b0;
      npu.burst_len        <= '0;
    end else begin
      done  <= 1'b0;
      error <= 1'b0;
      case (state)
        IDLE: begin
          if (start) begin
            if (src_addr[2:0] != 3'd0 || dst_addr[2:0] != 3'd0) begin
              error <= 1'b1;
            end else if (len_words == '0) begin
              done <= 1'b1;
            end else begin
              src            <= src_addr;
              dst            <= dst_addr;
              remaining      <= len_words;
              chunk          <= chunk_of(len_words);
              idx            <= '0;
              busy           <= 1'b1;
              npu.burst_mode <= 1'b1;
              npu.burst_len  <= chunk_of(len_words);
              state          <= RD;
            end
          end
        end

        // valid low on entry gives the one-cycle gap between phases
        RD: begin
          if (!npu.npu_valid) begin
            npu.npu_valid        <= 1'b1;
            npu.npu_write_enable <= 1'b0;
            npu.npu_byte_enable  <= 8'hFF;
            npu.npu_address      <= src;
          end else if (npu.npu_ready) begin
            buffer[idx[IW-1:0]] <= npu.npu_read_data;
            src                 <= src + 64'd8;
            if (last) begin
              npu.npu_valid       <= 1'b0;
              npu.npu_byte_enable <= '0;
              idx                 <= '0;
              state               <= WR;
            end else begin
              idx             <= idx + 4'd1;
              npu.npu_address <= src + 64'd8;
            end
          end
        end

        WR: begin
          if (!npu.npu_valid) begin
            npu.npu_valid        <= 1'b1;
            npu.npu_write_enable <= 1'b1;
            npu.npu_byte_enable  <= 8'hFF;
            npu.npu_address      <= dst;
            npu.npu_write_data   <= buffer[idx[IW-1:0]];
          end else if (npu.npu_ready) begin
            dst <= dst + 64'd8;
            if (last) begin
              npu.npu_valid        <= 1'b0;
              npu.npu_write_enable <= 1'b0;
              npu.npu_byte_enable  <= '0;
              idx                  <= '0;
              remaining            <= rem_after;
              if (rem_after == '0) begin
                done           <= 1'b1;
                npu.burst_mode <= 1'b0;
                npu.burst_len  <= '0;
                state          <= DONE;
              end else begin
                chunk         <= chunk_of(rem_after);
                npu.burst_len <= chunk_of(rem_after);
                state         <= RD;
              end
            end else begin
              idx                <= idx + 4'd1;
              npu.npu_address    <= dst + 64'd8;
              npu.npu_write_data <= buffer[IW'(idx + 4'd1)];
            end
          end
        end

        DONE: begin
          busy  <= 1'b0;
          state <= IDLE;
        end

        default: state <= IDLE;
      endcase
    end
  end

endmodule
